// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode encodings, default widths
// and the sequencer state type.
package alu_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int SEL_W_DEF  = 3;

  localparam logic [SEL_W_DEF-1:0] OP_ILL_LO = 3'b000;
  localparam logic [SEL_W_DEF-1:0] OP_ADD    = 3'b001;
  localparam logic [SEL_W_DEF-1:0] OP_SUB    = 3'b010;
  localparam logic [SEL_W_DEF-1:0] OP_NOT    = 3'b011;
  localparam logic [SEL_W_DEF-1:0] OP_CLR    = 3'b100;
  localparam logic [SEL_W_DEF-1:0] OP_OR     = 3'b101;
  localparam logic [SEL_W_DEF-1:0] OP_AND    = 3'b110;
  localparam logic [SEL_W_DEF-1:0] OP_ILL_HI = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // 000 and 111 are not ALU operations; everything else is.
  function automatic logic op_legal(input logic [SEL_W_DEF-1:0] sel);
    return (sel != OP_ILL_LO) && (sel != OP_ILL_HI);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant. A lone request always wins; when
// both request, the pointer names the winner. Grant is one-hot or zero.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  // Resolve the grant from the request vector and priority pointer
  always_comb begin
    gnt_o = 2'b00;
    if (req_i == 2'b11) begin
      gnt_o[ptr_i] = 1'b1;
    end else begin
      gnt_o = req_i;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin sequencer in front of a shared combinational ALU.
// One operation is in flight at a time: IDLE accepts, EXEC drives the ALU for
// a single cycle and captures its result, RESP holds the tagged result until
// the consumer takes it. Illegal opcodes (000/111) drive CLR and return 0
// with rsp_err set.
// Optional build macro ALU_ARB_ZERO_FLAG_EN adds a registered rsp_zero output.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = SEL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [SEL_W-1:0]  req1_sel,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
`ifdef ALU_ARB_ZERO_FLAG_EN
  output logic              rsp_zero,
`endif
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [SEL_W-1:0]  ALU_Sel,
  input  logic [DATA_W-1:0] ALU_Out
);

  arb_state_t        state_q, state_d;
  logic              ptr_q;
  logic [1:0]        gnt;
  logic              accept;

  logic [SEL_W-1:0]  sel_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic              id_q;
  logic              sel_legal;
  logic [DATA_W-1:0] exec_result;

  logic              rsp_id_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;

  rr_arb2 u_rr_arb2 (
    .req_i ({req1_valid, req0_valid}),
    .ptr_i (ptr_q),
    .gnt_o (gnt)
  );

  // A grant in IDLE is a handshake: the winner's ready follows its valid
  assign accept      = (state_q == IDLE) && (gnt != 2'b00);
  assign sel_legal   = op_legal(sel_q);
  assign exec_result = sel_legal ? ALU_Out : '0;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: EXEC always lasts one cycle, RESP waits for rsp_ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: readys only in IDLE, ALU driven only in EXEC, CLR otherwise
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    A          = '0;
    B          = '0;
    ALU_Sel    = SEL_W'(OP_CLR);
    rsp_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = gnt[0];
        req1_ready = gnt[1];
      end
      EXEC: begin
        A       = a_q;
        B       = b_q;
        ALU_Sel = sel_legal ? sel_q : SEL_W'(OP_CLR);
      end
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Operation latch: captures the winner's operands on the IDLE handshake
  always_ff @(posedge clk) begin
    if (accept) begin
      sel_q <= gnt[1] ? req1_sel : req0_sel;
      a_q   <= gnt[1] ? req1_a   : req0_a;
      b_q   <= gnt[1] ? req1_b   : req0_b;
      id_q  <= gnt[1];
    end
  end

  // Response registers and priority pointer; pointer flips to the requester
  // not served once the response is taken
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= 1'b0;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (state_q == EXEC) begin
        rsp_id_q   <= id_q;
        rsp_data_q <= exec_result;
        rsp_err_q  <= !sel_legal;
      end
      if ((state_q == RESP) && rsp_ready) begin
        ptr_q <= !rsp_id_q;
      end
    end
  end

  assign rsp_id   = rsp_id_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

`ifdef ALU_ARB_ZERO_FLAG_EN
  logic rsp_zero_q;

  // Zero flag tracks the captured result, including the forced-zero case
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_zero_q <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_zero_q <= (exec_result == '0);
    end
  end

  assign rsp_zero = rsp_zero_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a behavioural ALU, a round-robin
// reference model and directed plus randomized transactions.
module tb_alu_arbiter;

  localparam int DW = 16;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [SW-1:0] req0_sel, req1_sel;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [DW-1:0] rsp_data;
`ifdef ALU_ARB_ZERO_FLAG_EN
  logic          rsp_zero;
`endif
  logic [DW-1:0] A, B, ALU_Out;
  logic [SW-1:0] ALU_Sel;

  int n_cmp = 0;
  int n_bad = 0;
  bit m_ptr = 1'b0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(DW), .SEL_W(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_sel   (req0_sel),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_sel   (req1_sel),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
`ifdef ALU_ARB_ZERO_FLAG_EN
    .rsp_zero   (rsp_zero),
`endif
    .A          (A),
    .B          (B),
    .ALU_Sel    (ALU_Sel),
    .ALU_Out    (ALU_Out)
  );

  // Behavioural shared ALU
  always_comb begin
    case (ALU_Sel)
      3'b001:  ALU_Out = A + B;
      3'b010:  ALU_Out = A - B;
      3'b011:  ALU_Out = ~A;
      3'b100:  ALU_Out = '0;
      3'b101:  ALU_Out = A | B;
      3'b110:  ALU_Out = A & B;
      default: ALU_Out = 16'hDEAD;
    endcase
  end

  function automatic logic [DW-1:0] ref_result(input logic [SW-1:0] s,
                                                input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
    case (s)
      3'd1:    return a + b;
      3'd2:    return a - b;
      3'd3:    return ~a;
      3'd5:    return a | b;
      3'd6:    return a & b;
      default: return '0;
    endcase
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk1({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk1({tag, "_rsp_id"}, rsp_id, 1'b0);
    chk16({tag, "_rsp_data"}, rsp_data, 16'h0000);
    chk1({tag, "_rsp_err"}, rsp_err, 1'b0);
    chk1({tag, "_ready0"}, req0_ready, 1'b0);
    chk1({tag, "_ready1"}, req1_ready, 1'b0);
    chk16({tag, "_A"}, A, 16'h0000);
    chk16({tag, "_B"}, B, 16'h0000);
    chk16({tag, "_sel"}, {13'd0, ALU_Sel}, 16'h0004);
`ifdef ALU_ARB_ZERO_FLAG_EN
    chk1({tag, "_zero"}, rsp_zero, 1'b0);
`endif
  endtask

  // One complete transaction: offer, accept, EXEC, RESP with bp stall cycles
  task automatic transact(input bit v0, input bit v1,
                          input logic [SW-1:0] s0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                          input logic [SW-1:0] s1, input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                          input int bp);
    bit            win;
    bit            ill;
    logic [SW-1:0] s;
    logic [DW-1:0] a, b, r;
    win = (v0 && v1) ? m_ptr : !v0;
    s   = win ? s1 : s0;
    a   = win ? a1 : a0;
    b   = win ? b1 : b0;
    ill = (s == 3'b000) || (s == 3'b111);
    r   = ref_result(s, a, b);

    req0_valid = v0; req0_sel = s0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_sel = s1; req1_a = a1; req1_b = b1;
    rsp_ready  = (bp == 0);
    #1;
    chk1("offer_ready0", req0_ready, !win);
    chk1("offer_ready1", req1_ready, win);
    chk1("offer_rsp_valid", rsp_valid, 1'b0);

    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk16("exec_A", A, a);
    chk16("exec_B", B, b);
    chk16("exec_sel", {13'd0, ALU_Sel}, {13'd0, (ill ? 3'b100 : s)});
    chk1("exec_rsp_valid", rsp_valid, 1'b0);
    chk1("exec_ready0", req0_ready, 1'b0);
    chk1("exec_ready1", req1_ready, 1'b0);

    @(posedge clk); #1;
    for (int i = 0; i <= bp; i++) begin
      rsp_ready  = (i == bp);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      chk1("resp_valid", rsp_valid, 1'b1);
      chk16("resp_data", rsp_data, r);
      chk1("resp_id", rsp_id, win);
      chk1("resp_err", rsp_err, ill);
`ifdef ALU_ARB_ZERO_FLAG_EN
      chk1("resp_zero", rsp_zero, (r == 16'h0000));
`endif
      chk1("resp_ready0", req0_ready, 1'b0);
      chk1("resp_ready1", req1_ready, 1'b0);
      chk16("resp_sel_idle", {13'd0, ALU_Sel}, 16'h0004);
      @(posedge clk); #1;
    end
    m_ptr = !win;
    #1;
    chk1("post_rsp_valid", rsp_valid, 1'b0);
    chk1("post_ready0", req0_ready, !m_ptr);
    chk1("post_ready1", req1_ready, m_ptr);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
  endtask

  initial begin
    bit            rv0, rv1;
    logic [SW-1:0] rs0, rs1;
    logic [DW-1:0] ra0, rb0, ra1, rb1;
    int            rbp;

    rst = 1'b1;
    req0_valid = 1'b0; req0_sel = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_sel = '0; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Both requesters contending: 0, then 1, then 0 again
    transact(1'b1, 1'b1, 3'b110, 16'd3, 16'd5, 3'b101, 16'd3, 16'd5, 0);
    transact(1'b1, 1'b1, 3'b110, 16'd3, 16'd5, 3'b101, 16'd3, 16'd5, 0);
    transact(1'b1, 1'b1, 3'b110, 16'd3, 16'd5, 3'b101, 16'd3, 16'd5, 0);

    transact(1'b1, 1'b0, 3'b001, 16'h0003, 16'h0005, 3'b000, 16'd0, 16'd0, 0);
    transact(1'b0, 1'b1, 3'b000, 16'd0, 16'd0, 3'b010, 16'd3, 16'd5, 0);
    transact(1'b0, 1'b1, 3'b000, 16'd0, 16'd0, 3'b011, 16'd3, 16'd9, 0);
    transact(1'b1, 1'b0, 3'b111, 16'd3, 16'd5, 3'b001, 16'd1, 16'd1, 0);
    transact(1'b1, 1'b1, 3'b001, 16'hFFFF, 16'h0001, 3'b110, 16'hF0F0, 16'h0FF0, 4);

    for (int k = 0; k < 30; k++) begin
      rv0 = 1'($urandom_range(0, 1));
      rv1 = 1'($urandom_range(0, 1));
      if (!rv0 && !rv1) rv1 = 1'b1;
      rs0 = 3'($urandom_range(0, 7));
      rs1 = 3'($urandom_range(0, 7));
      ra0 = 16'($urandom); rb0 = 16'($urandom);
      ra1 = 16'($urandom); rb1 = 16'($urandom);
      rbp = int'($urandom_range(0, 3));
      transact(rv0, rv1, rs0, ra0, rb0, rs1, ra1, rb1, rbp);
    end

    // Reset in EXEC discards the operation and returns the pointer to 0
    transact(1'b1, 1'b0, 3'b001, 16'd1, 16'd2, 3'b000, 16'd0, 16'd0, 0);
    req1_valid = 1'b1; req1_sel = 3'b010; req1_a = 16'd7; req1_b = 16'd2;
    rsp_ready = 1'b1;
    #1;
    chk1("rstexec_ready1", req1_ready, 1'b1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    #1;
    chk16("rstexec_sel", {13'd0, ALU_Sel}, 16'h0002);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_idle_outputs("rstexec");
    m_ptr = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk1("rstexec_no_rsp", rsp_valid, 1'b0);
    end
    rsp_ready = 1'b0;
    transact(1'b1, 1'b1, 3'b101, 16'h00F0, 16'h000F, 3'b001, 16'd4, 16'd4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
